// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package arbiter_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } arb_op_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Round-robin choice between the two cache ports; a tie goes to the port not granted last.
module arb_rr_pick
   import arbiter_types::*;
(
   input  logic      i_req,
   input  logic      d_req,
   input  arb_port_t last_grant,
   output logic      grant_valid,
   output arb_port_t grant_port
);

   always_comb begin
      grant_valid = i_req | d_req;
      grant_port  = PORT_I;
      if (i_req && d_req) begin
         grant_port = (last_grant == PORT_I) ? PORT_D : PORT_I;
      end else if (d_req) begin
         grant_port = PORT_D;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between I-cache and D-cache, one whole line at a time.
module cache_arbiter
   import arbiter_types::*;
#(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_address,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_address,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   arb_state_t            state, state_next;
   arb_port_t             last_grant;
   arb_op_t               req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LINE_WIDTH-1:0] req_wdata;
   logic [LINE_WIDTH-1:0] i_rdata_q, d_rdata_q;
   logic                  grant_valid;
   arb_port_t             grant_port;
   logic                  serving;

   arb_rr_pick u_pick (
      .i_req       (icache_read),
      .d_req       (dcache_read | dcache_write),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = (grant_port == PORT_D) ? SERVE_D : SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request is captured once at grant so the cache may change its inputs while being served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= PORT_I;
         req_op     <= OP_READ;
         req_addr   <= '0;
         req_wdata  <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (state == IDLE && grant_valid) begin
            last_grant <= grant_port;
            if (grant_port == PORT_I) begin
               req_addr  <= icache_address;
               req_op    <= OP_READ;
               req_wdata <= '0;
            end else begin
               req_addr  <= dcache_address;
               req_op    <= dcache_write ? OP_WRITE : OP_READ;
               req_wdata <= dcache_wdata;
            end
         end
         if (icache_resp) begin
            i_rdata_q <= pmem_rdata;
         end
         if (dcache_resp && req_op == OP_READ) begin
            d_rdata_q <= pmem_rdata;
         end
      end
   end

   assign serving      = (state == SERVE_I) || (state == SERVE_D);
   assign pmem_read    = serving && (req_op == OP_READ);
   assign pmem_write   = serving && (req_op == OP_WRITE);
   assign pmem_address = req_addr;
   assign pmem_wdata   = req_wdata;
   assign icache_resp  = (state == SERVE_I) && pmem_resp;
   assign dcache_resp  = (state == SERVE_D) && pmem_resp;
   assign icache_rdata = icache_resp ? pmem_rdata : i_rdata_q;
   assign dcache_rdata = (dcache_resp && req_op == OP_READ) ? pmem_rdata : d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cache_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          icache_read = 1'b0;
   logic [AW-1:0] icache_address = '0;
   logic [LW-1:0] icache_rdata;
   logic          icache_resp;
   logic          dcache_read = 1'b0;
   logic          dcache_write = 1'b0;
   logic [AW-1:0] dcache_address = '0;
   logic [LW-1:0] dcache_wdata = '0;
   logic [LW-1:0] dcache_rdata;
   logic          dcache_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;

   always #5 clk = ~clk;

   cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_rdata   (icache_rdata),
      .icache_resp    (icache_resp),
      .dcache_read    (dcache_read),
      .dcache_write   (dcache_write),
      .dcache_address (dcache_address),
      .dcache_wdata   (dcache_wdata),
      .dcache_rdata   (dcache_rdata),
      .dcache_resp    (dcache_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // requester / responder controls
   bit            ri, rd, rd_wr;
   logic [AW-1:0] ri_addr, rd_addr;
   logic [LW-1:0] rd_wdata;
   int            ri_cyc;
   bit            drop_i, drop_d;
   bit            auto_req, rand_req, jitter, spurious, fixed_rdata_en;
   int            fixed_lat;
   logic [LW-1:0] fixed_rdata;
   int            resp_wait;

   // reference model: which port holds memory, what it asked for, when the port frees up
   int            m_cur, m_last, m_earliest;
   logic [AW-1:0] m_addr;
   bit            m_write;
   logic [LW-1:0] m_wdata;
   bit            s_i, s_d, s_dw;
   logic [AW-1:0] s_ia, s_da;
   logic [LW-1:0] s_dwd;
   logic [LW-1:0] exp_i_q;
   int            wait_i, wait_d;
   int            g_port[$];
   logic [AW-1:0] g_addr[$];
   int            g_cyc[$];
   int            r_cyc[$];

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = $urandom();
      a[4:0] = 5'd0;
      return a;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic bit all_idle();
      return (m_cur == -1) && !icache_read && !dcache_read && !dcache_write &&
             !ri && !rd && !drop_i && !drop_d;
   endfunction

   task automatic drive_phase();
      bit di, dd;
      di = drop_i;
      dd = drop_d;
      pmem_resp = 1'b0;
      if (di) begin icache_read = 1'b0; drop_i = 1'b0; end
      if (dd) begin dcache_read = 1'b0; dcache_write = 1'b0; drop_d = 1'b0; end
      if (jitter && icache_read) icache_address = rand_addr();
      if (jitter && (dcache_read || dcache_write)) begin
         dcache_address = rand_addr();
         dcache_wdata   = rand_line();
      end
      if (!icache_read && !di && !ri && (auto_req || (rand_req && $urandom_range(0, 3) == 0))) begin
         ri = 1'b1;
         ri_addr = rand_addr();
      end
      if (!dcache_read && !dcache_write && !dd && !rd &&
          (auto_req || (rand_req && $urandom_range(0, 3) == 0))) begin
         rd = 1'b1;
         rd_wr = 1'($urandom_range(0, 1));
         rd_addr = rand_addr();
         rd_wdata = rand_line();
      end
      if (ri && !icache_read && !di) begin
         icache_read = 1'b1;
         icache_address = ri_addr;
         ri = 1'b0;
         ri_cyc = cyc;
      end
      if (rd && !dcache_read && !dcache_write && !dd) begin
         dcache_read    = !rd_wr;
         dcache_write   = rd_wr;
         dcache_address = rd_addr;
         dcache_wdata   = rd_wdata;
         rd = 1'b0;
      end
      if (m_cur != -1) begin
         if (resp_wait == 0) pmem_resp = 1'b1;
         else resp_wait--;
      end else if (spurious && !s_i && !s_d && $urandom_range(0, 5) == 0) begin
         pmem_resp = 1'b1;
      end
      pmem_rdata = fixed_rdata_en ? fixed_rdata : rand_line();
   endtask

   task automatic sample_phase();
      int  want;
      bit  exp_rd, exp_wr, exp_ir, exp_dr;
      want = -1;
      if (m_cur == -1 && cyc >= m_earliest && (s_i || s_d)) begin
         if (s_i && s_d) want = (m_last == 0) ? 1 : 0;
         else want = s_i ? 0 : 1;
      end
      if (want != -1) begin
         m_cur  = want;
         m_last = want;
         if (want == 0) begin
            m_addr = s_ia; m_write = 1'b0; m_wdata = '0;
            wait_i = 0;
            if (s_d) wait_d++;
         end else begin
            m_addr = s_da; m_write = s_dw; m_wdata = s_dwd;
            wait_d = 0;
            if (s_i) wait_i++;
         end
         resp_wait = (fixed_lat >= 1) ? fixed_lat - 1 : int'($urandom_range(0, 3));
         g_port.push_back(want);
         g_addr.push_back(m_addr);
         g_cyc.push_back(cyc);
         n_cmp++;
         if (wait_i > 1 || wait_d > 1) begin
            n_bad++;
            $display("FAIL starvation cyc=%0d: waits i=%0d d=%0d, required <=1", cyc, wait_i, wait_d);
         end
      end
      exp_rd = (m_cur != -1) && !m_write;
      exp_wr = (m_cur != -1) && m_write;
      n_cmp++;
      if ({pmem_read, pmem_write} !== {exp_rd, exp_wr}) begin
         n_bad++;
         $display("FAIL pmem_rw cyc=%0d: got %b%b, required %b%b", cyc, pmem_read, pmem_write, exp_rd, exp_wr);
      end
      if (m_cur != -1) begin
         n_cmp++;
         if (pmem_address !== m_addr) begin
            n_bad++;
            $display("FAIL pmem_address cyc=%0d: got %h, required %h", cyc, pmem_address, m_addr);
         end
         if (m_write) begin
            n_cmp++;
            if (pmem_wdata !== m_wdata) begin
               n_bad++;
               $display("FAIL pmem_wdata cyc=%0d: got %h, required %h", cyc, pmem_wdata, m_wdata);
            end
         end
      end
      exp_ir = (m_cur == 0) && pmem_resp;
      exp_dr = (m_cur == 1) && pmem_resp;
      n_cmp++;
      if ({icache_resp, dcache_resp} !== {exp_ir, exp_dr}) begin
         n_bad++;
         $display("FAIL resp cyc=%0d: got i=%b d=%b, required i=%b d=%b", cyc, icache_resp, dcache_resp, exp_ir, exp_dr);
      end
      if (exp_ir) exp_i_q = pmem_rdata;
      n_cmp++;
      if (icache_rdata !== exp_i_q) begin
         n_bad++;
         $display("FAIL icache_rdata cyc=%0d: got %h, required %h", cyc, icache_rdata, exp_i_q);
      end
      if (exp_dr && !m_write) begin
         n_cmp++;
         if (dcache_rdata !== pmem_rdata) begin
            n_bad++;
            $display("FAIL dcache_rdata cyc=%0d: got %h, required %h", cyc, dcache_rdata, pmem_rdata);
         end
      end
      if (exp_ir || exp_dr) begin
         r_cyc.push_back(cyc);
         if (exp_ir) drop_i = 1'b1;
         else drop_d = 1'b1;
         m_cur = -1;
         m_earliest = cyc + 3;
      end
      s_i   = icache_read;
      s_d   = dcache_read | dcache_write;
      s_dw  = dcache_write;
      s_ia  = icache_address;
      s_da  = dcache_address;
      s_dwd = dcache_wdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      drive_phase();
      @(negedge clk);
      sample_phase();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      icache_read = 1'b0; icache_address = '0;
      dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;
      ri = 0; rd = 0; rd_wr = 0; drop_i = 0; drop_d = 0;
      auto_req = 0; rand_req = 0; jitter = 0; spurious = 0;
      fixed_lat = -1; fixed_rdata_en = 0; fixed_rdata = '0; resp_wait = 0;
      m_cur = -1; m_last = 0; m_earliest = 0; m_addr = '0; m_write = 0; m_wdata = '0;
      s_i = 0; s_d = 0; s_dw = 0; s_ia = '0; s_da = '0; s_dwd = '0;
      exp_i_q = '0; wait_i = 0; wait_d = 0;
      g_port.delete(); g_addr.delete(); g_cyc.delete(); r_cyc.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_until_idle(input int budget);
      int k;
      k = 0;
      while (k < budget && !all_idle()) begin
         step();
         k++;
      end
      n_cmp++;
      if (!all_idle()) begin
         n_bad++;
         $display("FAIL timeout cyc=%0d: still busy after %0d cycles, required idle", cyc, budget);
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, required 0000", {pmem_read, pmem_write, icache_resp, dcache_resp});
      end
      n_cmp++;
      if (pmem_address !== '0 || pmem_wdata !== '0) begin
         n_bad++;
         $display("FAIL reset_pmem: got addr %h wdata %h, required 0", pmem_address, pmem_wdata);
      end
      n_cmp++;
      if (icache_rdata !== '0 || dcache_rdata !== '0) begin
         n_bad++;
         $display("FAIL reset_rdata: got i %h d %h, required 0", icache_rdata, dcache_rdata);
      end
   endtask

   task automatic test_lone_i_read();
      logic [LW-1:0] a5;
      do_reset();
      for (int k = 0; k < LW / 8; k++) a5[k*8 +: 8] = 8'hA5;
      fixed_lat = 2; fixed_rdata_en = 1; fixed_rdata = a5;
      ri = 1; ri_addr = 32'h0000_0060;
      run_until_idle(30);
      n_cmp++;
      if (g_port.size() != 1 || g_port[0] != 0 || g_addr[0] !== 32'h60) begin
         n_bad++;
         $display("FAIL lone_i_grant: got %0d grants, required one I grant at 0x60", g_port.size());
      end
      n_cmp++;
      if (g_cyc.size() != 1 || g_cyc[0] != ri_cyc + 1) begin
         n_bad++;
         $display("FAIL lone_i_latency: grant not visible one cycle after request cycle %0d", ri_cyc);
      end
      n_cmp++;
      if (icache_rdata !== a5) begin
         n_bad++;
         $display("FAIL lone_i_rdata_hold: got %h, required %h", icache_rdata, a5);
      end
   endtask

   task automatic test_lone_d_write();
      do_reset();
      fixed_lat = 3;
      rd = 1; rd_wr = 1; rd_addr = 32'h0000_1000; rd_wdata = {8{32'h1234_5678}};
      run_until_idle(30);
      n_cmp++;
      if (g_port.size() != 1 || g_port[0] != 1 || g_addr[0] !== 32'h1000 || r_cyc.size() != 1) begin
         n_bad++;
         $display("FAIL lone_d_write: got %0d grants %0d resps, required one D write at 0x1000", g_port.size(), r_cyc.size());
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      fixed_lat = 2;
      ri = 1; ri_addr = 32'h100;
      rd = 1; rd_wr = 0; rd_addr = 32'h200;
      run_until_idle(40);
      n_cmp++;
      if (g_port.size() != 2 || g_port[0] != 1 || g_port[1] != 0 ||
          g_addr[0] !== 32'h200 || g_addr[1] !== 32'h100) begin
         n_bad++;
         $display("FAIL simultaneous_order: got %0d grants, required D@0x200 then I@0x100", g_port.size());
      end else begin
         n_cmp++;
         if (g_cyc[1] - r_cyc[0] != 3) begin
            n_bad++;
            $display("FAIL simultaneous_gap: got %0d cycles resp-to-grant, required 3", g_cyc[1] - r_cyc[0]);
         end
      end
   endtask

   task automatic test_contention();
      int k;
      do_reset();
      auto_req = 1;
      k = 0;
      while (g_port.size() < 6 && k < 200) begin
         step();
         k++;
      end
      auto_req = 0;
      run_until_idle(60);
      n_cmp++;
      if (g_port.size() < 6) begin
         n_bad++;
         $display("FAIL contention_count: got %0d grants, required 6", g_port.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (g_port[j] != ((j % 2 == 0) ? 1 : 0)) begin
               n_bad++;
               $display("FAIL contention_order[%0d]: got port %0d, required %0d", j, g_port[j], (j % 2 == 0) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_addr_change();
      do_reset();
      fixed_lat = 4;
      ri = 1; ri_addr = 32'h0000_0340;
      step();
      jitter = 1;
      run_until_idle(30);
      jitter = 0;
      n_cmp++;
      if (g_addr.size() != 1 || g_addr[0] !== 32'h340) begin
         n_bad++;
         $display("FAIL addr_change_latch: got %0d grants, required one at 0x340", g_addr.size());
      end
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      fixed_lat = 6;
      rd = 1; rd_wr = 1; rd_addr = 32'h2000; rd_wdata = rand_line();
      k = 0;
      while (m_cur != 1 && k < 10) begin
         step();
         k++;
      end
      step();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, dcache_resp} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_mid_drop: got rd=%b wr=%b dresp=%b, required 000", pmem_read, pmem_write, dcache_resp);
      end
      do_reset();
      ri = 1; ri_addr = 32'h80;
      step();
      rd = 1; rd_wr = 0; rd_addr = 32'h3000;
      run_until_idle(40);
      n_cmp++;
      if (g_port.size() != 2 || g_port[0] != 0 || g_port[1] != 1) begin
         n_bad++;
         $display("FAIL reset_mid_regrant: got %0d grants, required I then D", g_port.size());
      end
   endtask

   task automatic test_random();
      do_reset();
      rand_req = 1; jitter = 1; spurious = 1;
      repeat (600) step();
      rand_req = 0; spurious = 0;
      run_until_idle(100);
      jitter = 0;
      n_cmp++;
      if (g_port.size() < 20) begin
         n_bad++;
         $display("FAIL random_activity: got %0d grants, required at least 20", g_port.size());
      end
   endtask

   initial begin
      test_reset();
      test_lone_i_read();
      test_lone_d_write();
      test_simultaneous();
      test_contention();
      test_addr_change();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
